mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
Memory-access and write-back stage downstream of the execute datapath. It consumes the EX/MEM register outputs (ALU_ResultM, WriteDataM, RD_M, PCPlus4M plus M-stage controls) and performs loads and stores over a req/ready data-memory handshake. It stalls the pipeline while memory is busy, then registers the selected result into the MEM/WB register. ResultW, RDW and RegWriteW feed the register file write port and the forwarding muxes.

Parameters:
MAX_WAIT, 16, max cycles a dmem access may wait for dmem_ready before abort (>=2)

Ports:
CLK  in  1  clock, all state on posedge
rst  in  1  synchronous reset, active-high
ALU_ResultM  in  32  effective address / ALU result
WriteDataM  in  32  store data (forwarded rs2)
RD_M  in  5  destination register
PCPlus4M  in  32  link value
RegWriteM  in  1  instruction writes rd
MemWriteM  in  1  store
MemReadM  in  1  load
ResultSrcM  in  2  00 ALU, 01 load data, 10 PCPlus4, 11 ALU
Funct3M  in  3  access size/sign
dmem_req  out  1  access request
dmem_we  out  1  1 = write
dmem_addr  out  32  word address {ALU_ResultM[31:2],2'b00}
dmem_wdata  out  32  lane-replicated store data
dmem_be  out  4  byte enables
dmem_rdata  in  32  read data, valid when dmem_ready=1
dmem_ready  in  1  access completes at this posedge
StallM  out  1  freeze PC, IF/ID, ID/EX, EX/MEM this cycle
ResultW  out  32  write-back value
RDW  out  5  write-back register
RegWriteW  out  1  write-back enable
BusErrW  out  1  one-cycle pulse: access aborted on timeout
MisalignW  out  1  one-cycle pulse: misaligned access suppressed

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, wait counter=0, ResultW=0, RDW=0, RegWriteW=0, BusErrW=0, MisalignW=0. dmem_req and StallM forced 0 combinationally while rst=1.
- mem_op = MemReadM|MemWriteM. dmem_req = mem_op & ~rst & ~suppress (suppress only with optional feature). dmem_we = MemWriteM.
- All dmem_* outputs are combinational from the M inputs. Upstream holds the M inputs stable while StallM=1.
- Store lanes: SB (000): be=0001<<a[1:0], wdata={4{d[7:0]}}. SH (001): be=0011<<{a[1],0}, wdata={2{d[15:0]}}. SW (010): be=1111, wdata=d. Loads: be=1111.
- Load extract: LB/LBU (000/100) pick byte a[1:0]; LH/LHU (001/101) pick half a[1]; LW (010) full word. Sign-extend for 000/001, zero-extend for 100/101. Other funct3 return the full word.
- FSM has two states, IDLE and WAIT.
- IDLE: if dmem_req & dmem_ready, zero-wait completion: no stall, W register loads the instruction. If dmem_req & ~dmem_ready: StallM=1, go to WAIT, counter=1.
- WAIT: dmem_req held. If dmem_ready: StallM=0, W loads the instruction, go to IDLE. Otherwise StallM=1, counter++. When counter==MAX_WAIT-1 and still ~dmem_ready: abort. StallM=0, W gets a bubble (RegWriteW=0, RDW=0), BusErrW=1 next cycle, go to IDLE, counter=0.
- Stall cycles per access = number of cycles dmem_ready is low, capped at MAX_WAIT-1.
- MEM/WB register, each non-reset posedge:
  - StallM=1: bubble (RegWriteW=0, RDW=0, ResultW holds).
  - Otherwise: RDW=RD_M, RegWriteW=RegWriteM, ResultW=mux(ResultSrcM).
- Non-memory instructions pass through with 1-cycle latency and never stall.
- rst asserted in WAIT: abandon the access, return to IDLE, no BusErrW. A dmem_ready arriving in the reset cycle is ignored.
- dmem_ready while dmem_req=0 is ignored.
- BusErrW and MisalignW are single-cycle, aligned with the bubbled W slot.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: misaligned access (half with a[0]=1; word with a[1:0]!=0) sets suppress=1, so no dmem_req, no stall. W slot is a bubble and MisalignW=1 next cycle.
- Undefined: no check. Half access uses a[1] only; word access ignores a[1:0]. MisalignW tied 0.

Test Plan:
- ALU op: ALU_ResultM=0x12345678, RD_M=5, RegWriteM=1, ResultSrcM=00 -> next cycle ResultW=0x12345678, RDW=5, RegWriteW=1; StallM never 1.
- LB, addr 0x103, dmem_rdata=0x80FF_0000, ready same cycle -> be=1111, dmem_addr=0x100, ResultW=0xFFFFFF80; LBU same -> 0x00000080; no stall.
- SH, addr 0x0A, WriteDataM=0xAAAA_BEEF, ready after 3 low cycles -> be=1100, wdata=0xBEEFBEEF, dmem_addr=0x08. StallM high exactly 3 cycles, W bubbles during the stall, RegWriteM=0 passes through on completion.
- Timeout MAX_WAIT=16, LW with dmem_ready stuck 0 -> StallM high 15 cycles, then BusErrW pulse and RegWriteW=0; the next instruction proceeds normally.
- rst=1 on the 2nd WAIT cycle -> state IDLE, all W outputs 0, dmem_req=0 during reset, no BusErrW.
- With MISALIGN_TRAP_EN, LW at 0x102 -> dmem_req=0, MisalignW=1, RegWriteW=0. Without it -> access issued at 0x100 and the word is returned.

Source files
------------

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: data-memory access over a req/ready handshake plus the MEM/WB register.
// Optional misaligned-access trap enabled by defining MISALIGN_TRAP_EN.
module mem_wb_stage #(
    parameter int MAX_WAIT = 16
) (
    input  logic        CLK,
    input  logic        rst,
    input  logic [31:0] ALU_ResultM,
    input  logic [31:0] WriteDataM,
    input  logic [4:0]  RD_M,
    input  logic [31:0] PCPlus4M,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic        MemReadM,
    input  logic [1:0]  ResultSrcM,
    input  logic [2:0]  Funct3M,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic        StallM,
    output logic [31:0] ResultW,
    output logic [4:0]  RDW,
    output logic        RegWriteW,
    output logic        BusErrW,
    output logic        MisalignW
);
    localparam int CW = $clog2(MAX_WAIT + 1);
    typedef enum logic {IDLE, WAIT} state_t;
    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [1:0]     a;
    logic           mem_op, suppress, at_limit, abort;
    logic [7:0]     ld_b;
    logic [15:0]    ld_h;
    logic [31:0]    load_data, result_m;
    assign a      = ALU_ResultM[1:0];
    assign mem_op = MemReadM | MemWriteM;
`ifdef MISALIGN_TRAP_EN
    assign suppress = mem_op & ((Funct3M[1:0] == 2'b01 & a[0]) | (Funct3M == 3'b010 & a != 2'b00));
`else
    assign suppress = 1'b0;
`endif
    assign dmem_req  = mem_op & ~rst & ~suppress;
    assign dmem_we   = MemWriteM;
    assign dmem_addr = {ALU_ResultM[31:2], 2'b00};
    always_comb begin
        dmem_be    = 4'b1111;
        dmem_wdata = WriteDataM;
        if (MemWriteM && Funct3M == 3'b000) begin
            dmem_be    = 4'b0001 << a;
            dmem_wdata = {4{WriteDataM[7:0]}};
        end else if (MemWriteM && Funct3M == 3'b001) begin
            dmem_be    = 4'b0011 << {a[1], 1'b0};
            dmem_wdata = {2{WriteDataM[15:0]}};
        end
    end
    assign ld_b = dmem_rdata[{a, 3'b000} +: 8];
    assign ld_h = dmem_rdata[{a[1], 4'b0000} +: 16];
    always_comb begin
        load_data = dmem_rdata;
        case (Funct3M)
            3'b000:  load_data = {{24{ld_b[7]}}, ld_b};
            3'b100:  load_data = {24'd0, ld_b};
            3'b001:  load_data = {{16{ld_h[15]}}, ld_h};
            3'b101:  load_data = {16'd0, ld_h};
            default: load_data = dmem_rdata;
        endcase
    end
    assign result_m = ResultSrcM == 2'b01 ? load_data :
                      ResultSrcM == 2'b10 ? PCPlus4M : ALU_ResultM;
    // The last permitted wait cycle aborts instead of stalling again.
    assign at_limit = state_q == WAIT && cnt_q == CW'(MAX_WAIT - 1);
    assign abort    = dmem_req & ~dmem_ready & at_limit;
    assign StallM   = dmem_req & ~dmem_ready & ~at_limit;
    always_comb begin
        state_d = StallM ? WAIT : IDLE;
        cnt_d   = StallM ? cnt_q + 1'b1 : '0;
    end
    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ResultW   <= '0;
            RDW       <= '0;
            RegWriteW <= 1'b0;
            BusErrW   <= 1'b0;
            MisalignW <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            BusErrW   <= abort;
            MisalignW <= suppress;
            if (StallM | abort | suppress) begin
                RDW       <= '0;
                RegWriteW <= 1'b0;
            end else begin
                RDW       <= RD_M;
                RegWriteW <= RegWriteM;
                ResultW   <= result_m;
            end
        end
    end
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: randomized and directed checks of mem_wb_stage against a transaction-level model.
// Honours MISALIGN_TRAP_EN the same way the design does.
module tb_mem_wb_stage;
    localparam int MAXW = 16;
    logic        CLK = 1'b0, rst;
    logic [31:0] ALU_ResultM, WriteDataM, PCPlus4M, dmem_addr, dmem_wdata, dmem_rdata, ResultW;
    logic [4:0]  RD_M, RDW;
    logic        RegWriteM, MemWriteM, MemReadM, dmem_req, dmem_we, dmem_ready, StallM;
    logic        RegWriteW, BusErrW, MisalignW;
    logic [1:0]  ResultSrcM;
    logic [2:0]  Funct3M;
    logic [3:0]  dmem_be;
    int          vectors = 0, miscompares = 0;
    logic [31:0] exp_res = '0;

    mem_wb_stage #(.MAX_WAIT(MAXW)) dut (
        .CLK(CLK), .rst(rst), .ALU_ResultM(ALU_ResultM), .WriteDataM(WriteDataM), .RD_M(RD_M),
        .PCPlus4M(PCPlus4M), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemReadM(MemReadM),
        .ResultSrcM(ResultSrcM), .Funct3M(Funct3M), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
        .dmem_ready(dmem_ready), .StallM(StallM), .ResultW(ResultW), .RDW(RDW),
        .RegWriteW(RegWriteW), .BusErrW(BusErrW), .MisalignW(MisalignW)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] ld_val(logic [31:0] d, logic [31:0] a, logic [2:0] f3);
        logic [31:0] b = (d >> (8 * (a % 4))) & 32'hFF;
        logic [31:0] h = (d >> (16 * ((a / 2) % 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return b >= 128 ? b + 32'hFFFFFF00 : b;
            3'd4:    return b;
            3'd1:    return h >= 32768 ? h + 32'hFFFF0000 : h;
            3'd5:    return h;
            default: return d;
        endcase
    endfunction

    function automatic bit misaligned(logic [31:0] a, logic [2:0] f3);
`ifdef MISALIGN_TRAP_EN
        return ((f3 == 3'd1 || f3 == 3'd5) && a % 2 != 0) || (f3 == 3'd2 && a % 4 != 0);
`else
        return 1'b0;
`endif
    endfunction

    // One instruction at M; memory answers after k low-ready cycles.
    task automatic exec(input string nm, input logic [31:0] alu, input logic [31:0] wd,
                        input logic [31:0] pc, input logic [31:0] rdata, input logic [4:0] rd,
                        input logic rw, input logic mw, input logic mr, input logic [1:0] src,
                        input logic [2:0] f3, input int k);
        bit          mem = mw | mr;
        bit          mis = mem && misaligned(alu, f3);
        bit          iss = mem && !mis;
        int          ns  = iss ? (k < MAXW - 1 ? k : MAXW - 1) : 0;
        bit          tmo = iss && k >= MAXW - 1;
        logic [3:0]  ebe = 4'hF;
        logic [31:0] ewd = wd;
        logic [39:0] ew;
        if (mw && f3 == 3'd0) begin
            ebe = 4'b0001 << (alu % 4);
            ewd = {4{wd[7:0]}};
        end else if (mw && f3 == 3'd1) begin
            ebe = 4'b0011 << (alu & 32'd2);
            ewd = {2{wd[15:0]}};
        end
        for (int c = 0; c <= ns; c++) begin
            @(negedge CLK);
            ALU_ResultM = alu; WriteDataM = wd; PCPlus4M = pc; dmem_rdata = rdata; RD_M = rd;
            RegWriteM = rw; MemWriteM = mw; MemReadM = mr; ResultSrcM = src; Funct3M = f3;
            dmem_ready = iss ? (c >= k) : 1'($urandom);
            #1;
            vectors++;
            if ({dmem_req, StallM} !== {iss, c < ns}) begin
                miscompares++;
                $display("FAIL %s req/stall cyc%0d: got %b expected %b", nm, c, {dmem_req, StallM}, {iss, c < ns});
            end
            if (iss) begin
                vectors++;
                if ({dmem_addr, dmem_we, dmem_be} !== {alu & ~32'h3, mw, ebe}) begin
                    miscompares++;
                    $display("FAIL %s addr/we/be cyc%0d: got %h/%b/%b expected %h/%b/%b", nm, c,
                             dmem_addr, dmem_we, dmem_be, alu & ~32'h3, mw, ebe);
                end
                if (mw) begin
                    vectors++;
                    if (dmem_wdata !== ewd) begin
                        miscompares++;
                        $display("FAIL %s wdata cyc%0d: got %h expected %h", nm, c, dmem_wdata, ewd);
                    end
                end
            end
            @(posedge CLK); #1;
            if (c < ns) ew = {exp_res, 5'd0, 1'b0, 1'b0, 1'b0};
            else if (tmo || mis) ew = {exp_res, 5'd0, 1'b0, tmo, mis};
            else begin
                exp_res = src == 2'b01 ? ld_val(rdata, alu, f3) : src == 2'b10 ? pc : alu;
                ew = {exp_res, rd, rw, 1'b0, 1'b0};
            end
            vectors++;
            if ({ResultW, RDW, RegWriteW, BusErrW, MisalignW} !== ew) begin
                miscompares++;
                $display("FAIL %s wb cyc%0d: got %h expected %h", nm, c,
                         {ResultW, RDW, RegWriteW, BusErrW, MisalignW}, ew);
            end
        end
    endtask

    task automatic test_reset();
        @(negedge CLK);
        rst = 1'b1; MemReadM = 1'b1; Funct3M = 3'd2; ALU_ResultM = 32'h40; dmem_ready = 1'b0;
        #1;
        vectors++;
        if ({dmem_req, StallM} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset req/stall: got %b expected 00", {dmem_req, StallM});
        end
        @(posedge CLK); #1;
        vectors++;
        if ({ResultW, RDW, RegWriteW, BusErrW, MisalignW} !== 40'd0) begin
            miscompares++;
            $display("FAIL reset wb: got %h expected 0", {ResultW, RDW, RegWriteW, BusErrW, MisalignW});
        end
        exp_res = '0;
        rst = 1'b0;
    endtask

    task automatic test_alu();
        exec("alu_dir", 32'h12345678, 32'h0, 32'h104, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 2'b00, 3'd0, 0);
        vectors++;
        if ({ResultW, RDW, RegWriteW} !== {32'h12345678, 5'd5, 1'b1}) begin
            miscompares++;
            $display("FAIL alu_dir value: got %h/%0d/%b expected 12345678/5/1", ResultW, RDW, RegWriteW);
        end
        exec("jal_link", 32'h0, 32'h0, 32'h2000, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 2'b10, 3'd0, 3);
        exec("alu_src11", 32'hCAFEF00D, 32'h0, 32'h8, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0, 2'b11, 3'd0, 0);
    endtask

    task automatic test_load();
        exec("lb", 32'h103, 32'h0, 32'h0, 32'h80FF_0000, 5'd6, 1'b1, 1'b0, 1'b1, 2'b01, 3'd0, 0);
        vectors++;
        if (ResultW !== 32'hFFFFFF80) begin
            miscompares++;
            $display("FAIL lb value: got %h expected ffffff80", ResultW);
        end
        exec("lbu", 32'h103, 32'h0, 32'h0, 32'h80FF_0000, 5'd7, 1'b1, 1'b0, 1'b1, 2'b01, 3'd4, 0);
        vectors++;
        if (ResultW !== 32'h00000080) begin
            miscompares++;
            $display("FAIL lbu value: got %h expected 00000080", ResultW);
        end
        exec("lh", 32'h202, 32'h0, 32'h0, 32'h9abc_1234, 5'd8, 1'b1, 1'b0, 1'b1, 2'b01, 3'd1, 2);
        exec("lhu", 32'h202, 32'h0, 32'h0, 32'h9abc_1234, 5'd8, 1'b1, 1'b0, 1'b1, 2'b01, 3'd5, 1);
    endtask

    task automatic test_store();
        exec("sh_wait3", 32'h0A, 32'hAAAA_BEEF, 32'h0, 32'h0, 5'd3, 1'b0, 1'b1, 1'b0, 2'b00, 3'd1, 3);
        exec("sb", 32'h31, 32'h1234_56A5, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0, 2'b00, 3'd0, 1);
        exec("sw", 32'h40, 32'hDEAD_BEEF, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0, 2'b00, 3'd2, 0);
    endtask

    task automatic test_timeout();
        exec("lw_timeout", 32'h80, 32'h0, 32'h0, 32'h5555_AAAA, 5'd10, 1'b1, 1'b0, 1'b1, 2'b01, 3'd2, 100);
        exec("after_timeout", 32'h77, 32'h0, 32'h0, 32'h0, 5'd11, 1'b1, 1'b0, 1'b0, 2'b00, 3'd0, 0);
        exec("lw_at_limit", 32'h84, 32'h0, 32'h0, 32'h0BAD_F00D, 5'd12, 1'b1, 1'b0, 1'b1, 2'b01, 3'd2, MAXW - 2);
    endtask

    task automatic test_reset_in_wait();
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            ALU_ResultM = 32'h300; MemReadM = 1'b1; MemWriteM = 1'b0; Funct3M = 3'd2;
            RegWriteM = 1'b1; RD_M = 5'd4; ResultSrcM = 2'b01; dmem_rdata = 32'h1111_2222;
            rst = c == 2; dmem_ready = c == 2;
            #1;
            vectors++;
            if ({dmem_req, StallM} !== {c < 2, c < 2}) begin
                miscompares++;
                $display("FAIL rst_wait req/stall cyc%0d: got %b expected %b", c, {dmem_req, StallM}, {c < 2, c < 2});
            end
            @(posedge CLK); #1;
        end
        vectors++;
        if ({ResultW, RDW, RegWriteW, BusErrW, MisalignW} !== 40'd0) begin
            miscompares++;
            $display("FAIL rst_wait wb: got %h expected 0", {ResultW, RDW, RegWriteW, BusErrW, MisalignW});
        end
        exp_res = '0;
        rst = 1'b0;
        exec("after_rst", 32'hABCD, 32'h0, 32'h0, 32'h0, 5'd2, 1'b1, 1'b0, 1'b0, 2'b00, 3'd0, 0);
        exec("ld_after_rst", 32'h304, 32'h0, 32'h0, 32'h7777_0001, 5'd3, 1'b1, 1'b0, 1'b1, 2'b01, 3'd2, 2);
    endtask

    task automatic test_misalign();
        exec("lw_0x102", 32'h102, 32'h0, 32'h0, 32'hFEED_C0DE, 5'd13, 1'b1, 1'b0, 1'b1, 2'b01, 3'd2, 0);
        vectors++;
`ifdef MISALIGN_TRAP_EN
        if ({RegWriteW, MisalignW} !== 2'b01) begin
            miscompares++;
            $display("FAIL lw_0x102 trap: got rw=%b mis=%b expected rw=0 mis=1", RegWriteW, MisalignW);
        end
`else
        if ({ResultW, RegWriteW, MisalignW} !== {32'hFEED_C0DE, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL lw_0x102 word: got %h rw=%b mis=%b expected feedc0de rw=1 mis=0", ResultW, RegWriteW, MisalignW);
        end
`endif
        exec("sh_odd", 32'h0B, 32'h0000_1357, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0, 2'b00, 3'd1, 1);
        exec("lh_odd", 32'h101, 32'h0, 32'h0, 32'h8001_7FFE, 5'd14, 1'b1, 1'b0, 1'b1, 2'b01, 3'd1, 0);
        exec("after_mis", 32'h55, 32'h0, 32'h0, 32'h0, 5'd15, 1'b1, 1'b0, 1'b0, 2'b00, 3'd0, 0);
    endtask

    task automatic test_random(input int n, input int kmax);
        logic [2:0] f3s [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        for (int i = 0; i < n; i++) begin
            int op = $urandom_range(0, 2);
            int k  = $urandom_range(0, 14) == 0 ? 20 : $urandom_range(0, kmax);
            exec("rand", $urandom, $urandom, $urandom, $urandom, 5'($urandom), op != 2 ? 1'($urandom) : 1'b0,
                 op == 2, op == 1, op == 1 ? 2'b01 : 2'($urandom), f3s[$urandom_range(0, 4)], k);
        end
    endtask

    initial begin
        rst = 1'b1; ALU_ResultM = '0; WriteDataM = '0; PCPlus4M = '0; RD_M = '0; RegWriteM = 1'b0;
        MemWriteM = 1'b0; MemReadM = 1'b0; ResultSrcM = '0; Funct3M = '0; dmem_rdata = '0; dmem_ready = 1'b0;
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_timeout();
        test_reset_in_wait();
        test_misalign();
        test_random(20, 0);
        test_random(150, 5);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
